// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - width helpers and 3:2 compressor primitive for carry-save trees
package csa_pkg;

  localparam int CSA_MAXW = 64;

  typedef logic [CSA_MAXW-1:0] csa_vec_t;

  typedef struct packed {
    csa_vec_t sum;
    csa_vec_t carry;
  } fa3_t;

  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

  function automatic int out_width(input int w, input int n, input int ext);
    return sum_width(w, n) + ext;
  endfunction

  // Vector count after a given number of 3:2 layers.
  function automatic int tree_count(input int n, input int layer);
    int c;
    c = n;
    for (int i = 0; i < layer; i++) c = c - c / 3;
    return c;
  endfunction

  function automatic int tree_layers(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = c - c / 3;
      l++;
    end
    return l;
  endfunction

  function automatic fa3_t fa3(input csa_vec_t a, input csa_vec_t b, input csa_vec_t c);
    fa3_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/csa_sum_pipe_if.sv
// rtl/csa_sum_pipe_if.sv - operand/result handshake bundle for csa_sum_pipe
interface csa_sum_pipe_if
  import csa_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int ACC_EXT = 4
);
  localparam int OW = out_width(W, N, ACC_EXT);

  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_data;
  logic            in_acc;
  logic            acc_clr;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_sum;
  logic            out_parity;
  logic            out_ovf;

  modport master (
    output in_valid, in_data, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_sum, out_parity, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_sum, out_parity, out_ovf
  );

endinterface

// File: rtl/csa_tree.sv
// rtl/csa_tree.sv - combinational N-to-2 Wallace reduction of unsigned operands
module csa_tree
  import csa_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = sum_width(W, N)
) (
  input  logic [N*W-1:0] ops,
  output logic [SW-1:0]  sum,
  output logic [SW-1:0]  carry
);
  localparam int NL = tree_layers(N);

  logic [SW-1:0] lay [0:NL][0:N-1];

  for (genvar k = 0; k < N; k++) begin : g_in
    assign lay[0][k] = SW'(ops[k*W +: W]);
  end

  // Each layer compresses groups of three into two; leftovers pass straight down.
  for (genvar l = 0; l < NL; l++) begin : g_layer
    localparam int C = tree_count(N, l);
    localparam int G = C / 3;

    for (genvar g = 0; g < G; g++) begin : g_fa
      logic [CSA_MAXW-SW-1:0] s_unused;
      logic [CSA_MAXW-SW-1:0] c_unused;
      assign {s_unused, lay[l+1][2*g], c_unused, lay[l+1][2*g+1]} =
        fa3(CSA_MAXW'(lay[l][3*g]), CSA_MAXW'(lay[l][3*g+1]), CSA_MAXW'(lay[l][3*g+2]));
    end

    for (genvar k = 0; k < C - 3*G; k++) begin : g_pass
      assign lay[l+1][2*G+k] = lay[l][3*G+k];
    end

    for (genvar k = C - G; k < N; k++) begin : g_zero
      assign lay[l+1][k] = '0;
    end
  end

  assign sum   = lay[NL][0];
  assign carry = lay[NL][1];

endmodule

// File: rtl/csa_sum_pipe.sv
// rtl/csa_sum_pipe.sv - two-stage carry-save multi-operand adder with accumulator
module csa_sum_pipe
  import csa_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int ACC_EXT = 4
) (
  input logic          clk,
  input logic          rst_n,
  csa_sum_pipe_if.slave bus
);
  localparam int SW = sum_width(W, N);
  localparam int OW = SW + ACC_EXT;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [SW-1:0] carry;
    logic          parity;
    logic          acc;
  } s1_payload_t;

  s1_payload_t   s1_d;
  s1_payload_t   s1_q;
  logic          s1_valid;
  logic [SW-1:0] tree_sum;
  logic [SW-1:0] tree_carry;
  logic [SW-1:0] cpa;
  logic [OW-1:0] plain_sum;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] acc_base;
  logic [OW:0]   acc_sum;
  logic          ovf_q;
  logic          s2_advance;
  logic          in_fire;
  logic          commit;

  csa_tree #(.W(W), .N(N), .SW(SW)) u_tree (
    .ops   (bus.in_data),
    .sum   (tree_sum),
    .carry (tree_carry)
  );

  assign s2_advance   = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_advance;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign commit       = s1_valid & s2_advance;

  assign s1_d.sum    = tree_sum;
  assign s1_d.carry  = tree_carry;
  assign s1_d.parity = ^bus.in_data;
  assign s1_d.acc    = bus.in_acc;

  // Add in SW bits: the truncated carry-save pair is only exact modulo 2^SW.
  assign cpa       = s1_q.sum + s1_q.carry;
  assign plain_sum = OW'(cpa);
  assign acc_base  = bus.acc_clr ? '0 : acc_q;
  assign acc_sum   = {1'b0, acc_base} + {1'b0, plain_sum};
  assign bus.out_ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_q           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sum    <= '0;
      bus.out_parity <= 1'b0;
      acc_q          <= '0;
      ovf_q          <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_fire) s1_q <= s1_d;
      if (s2_advance) bus.out_valid <= s1_valid;
      if (commit) begin
        bus.out_parity <= s1_q.parity;
        bus.out_sum    <= s1_q.acc ? acc_sum[OW-1:0] : plain_sum;
      end
      if (commit && s1_q.acc) begin
        acc_q <= acc_sum[OW-1:0];
        ovf_q <= (ovf_q & ~bus.acc_clr) | acc_sum[OW];
      end else if (bus.acc_clr) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_sum_pipe.sv
// tb/tb_csa_sum_pipe.sv - randomized self-checking bench for csa_sum_pipe
module tb_csa_sum_pipe;
  localparam int W       = 8;
  localparam int N       = 4;
  localparam int ACC_EXT = 4;
  localparam int OW      = W + $clog2(N) + ACC_EXT;
  localparam longint MOD = longint'(1) << OW;

  typedef struct {
    longint sum;
    bit     par;
    bit     acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  csa_sum_pipe_if #(.W(W), .N(N), .ACC_EXT(ACC_EXT)) bus ();

  csa_sum_pipe #(.W(W), .N(N), .ACC_EXT(ACC_EXT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  int     n_out = 0;
  exp_t   exp_q[$];
  longint acc_m = 0;
  bit     ovf_m = 1'b0;
  longint last_sum = 0;
  bit     rnd_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sum(input logic [N*W-1:0] d);
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(d[k*W +: W]);
    return s;
  endfunction

  // Reference model: expectations captured at input handshake, retired in order at output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_m = 0;
      ovf_m = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t   e;
          longint es;
          bit     eo;
          e = exp_q[0];
          if (e.acc) begin
            es = (acc_m + e.sum) % MOD;
            eo = ovf_m | ((acc_m + e.sum) >= MOD);
          end else begin
            es = e.sum;
            eo = ovf_m;
          end
          check("out_sum", 32'(bus.out_sum), 32'(es));
          check("out_parity", 32'(bus.out_parity), 32'(e.par));
          check("out_ovf", 32'(bus.out_ovf), 32'(eo));
          if (bus.out_ready) begin
            if (e.acc) acc_m = es;
            ovf_m = eo;
            last_sum = longint'(bus.out_sum);
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{sum: ref_sum(bus.in_data), par: ^bus.in_data, acc: bus.in_acc});
    end
  end

  task automatic send(input logic [N*W-1:0] d, input logic acc);
    bit ok;
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_acc   = acc;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clr_idle();
    bus.acc_clr = 1'b1;
    acc_m = 0;
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
  endtask

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_acc    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_parity", 32'(bus.out_parity), 32'd0);
    check("rst_ovf", 32'(bus.out_ovf), 32'd0);

    // single transfer, latency and one-cycle pulse
    send(32'h04030201, 1'b0);
    check("lat1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat2_valid", 32'(bus.out_valid), 32'd1);
    check("t1_sum", 32'(bus.out_sum), 32'd10);
    check("t1_parity", 32'(bus.out_parity), 32'd1);
    @(posedge clk); #1;
    check("pulse_end", 32'(bus.out_valid), 32'd0);

    // maximum operands
    send(32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    check("max_sum", 32'(bus.out_sum), 32'd1020);
    check("max_parity", 32'(bus.out_parity), 32'd0);
    check("max_ovf", 32'(bus.out_ovf), 32'd0);
    drain();

    // backpressure
    base = n_out;
    bus.out_ready = 1'b0;
    send(32'($urandom), 1'b0);
    send(32'($urandom), 1'b0);
    @(negedge clk);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 3; i++) send(32'($urandom), 1'b0);
      end
    join
    drain();
    check("bp_count", 32'(n_out - base), 32'd5);

    // accumulate, then clear on the same edge as an accumulating commit
    clr_idle();
    send(32'h19191919, 1'b1);
    send(32'h32323232, 1'b1);
    send(32'h0C0C0D0D, 1'b1);
    drain();
    check("acc_350", 32'(last_sum), 32'd350);
    send(32'h01030201, 1'b1);
    bus.acc_clr = 1'b1;
    acc_m = 0;
    ovf_m = 1'b0;
    @(posedge clk); #1;
    bus.acc_clr = 1'b0;
    drain();
    check("clr_add", 32'(last_sum), 32'd7);

    // overflow wrap and sticky flag
    clr_idle();
    for (int i = 0; i < 17; i++) send(32'hFFFFFFFF, 1'b1);
    drain();
    check("ovf_wrap", 32'(last_sum), 32'd956);
    check("ovf_set", 32'(bus.out_ovf), 32'd1);
    send(32'h00000005, 1'b0);
    drain();
    check("ovf_sticky", 32'(bus.out_ovf), 32'd1);
    clr_idle();
    check("ovf_cleared", 32'(bus.out_ovf), 32'd0);

    // reset with two transactions in flight
    send(32'h11111111, 1'b1);
    send(32'h22222222, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst_stale", 32'(bus.out_valid), 32'd0);
    send(32'h10203040, 1'b1);
    drain();
    check("midrst_acc", 32'(last_sum), 32'd160);

    // randomized traffic with random stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send(($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : 32'($urandom), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/csa_sum_pipe.md
Name: csa_sum_pipe

Overview:
- Pipelined multi-operand adder built around a carry-save (3:2 compressor) tree.
- Parametrised successor to the team's flat combinational XOR/majority sum logic: configurable operand count and width, valid/ready flow control, an optional accumulate mode and a parity side output.
- Sits between operand sources and downstream consumers; replaces hand-flattened sum netlists in the datapath.

Parameters:
- W, 8, bit width of each input operand (unsigned), W >= 2.
- N, 4, number of operands per transaction, 3 <= N <= 16.
- ACC_EXT, 4, extra accumulator guard bits beyond sum width.
- OW, W + $clog2(N) + ACC_EXT, derived output width; not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept the bundle this cycle.
- in_data  in  N*W  operands packed; operand k at bits [k*W +: W].
- in_acc  in  1  1 = add the sum into the accumulator; 0 = plain sum.
- acc_clr  in  1  clear the accumulator (sideband, no handshake).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  OW  result: plain sum or accumulator value.
- out_parity  out  1  XOR of all N*W input bits of this transaction.
- out_ovf  out  1  accumulator wrapped on this transaction (sticky until acc_clr).

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - All valid flags, the accumulator and the overflow flag go to 0.
  - out_sum=0, out_parity=0, out_ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation drops every in-flight transaction with no output.
- Pipeline has 2 stages; latency is exactly 2 cycles from the input handshake to out_valid when not stalled.
  - S1: the combinational compressor tree reduces N operands to sum and carry vectors of width OW-ACC_EXT. S1 registers those vectors, the parity and in_acc.
  - S2: carry-propagate add of sum+carry, zero-extended to OW. S2 registers the result into out_sum.
- Throughput is 1 transaction per cycle.
- Handshake:
  - A transfer occurs when valid&ready are both high.
  - Each stage advances when its downstream is empty or being drained.
  - in_ready = ~s1_valid | s2_advance (combinational, no dependency on in_valid).
  - While out_valid=1 and out_ready=0, out_* stay stable and the pipeline holds. No data is lost or duplicated.
- Accumulate mode:
  - When a transaction with in_acc=1 enters S2: acc <= acc + sum (mod 2^OW), and out_sum = the new acc.
  - If the addition carries out of bit OW-1, out_ovf is set and stays set.
  - With in_acc=0, out_sum = sum and acc is unchanged; out_ovf shows its current sticky value.
- acc_clr=1:
  - acc and out_ovf go to 0 at the next edge.
  - If that same edge also commits an in_acc=1 transaction, the result is 0 + sum (clear first, then add).
  - acc_clr does not affect valid flags or out_sum already held.
- Arithmetic:
  - Operands are unsigned.
  - The plain sum of N operands of maximum value (N*(2^W-1)) must be exact; it never overflows.
- Parity is computed in S1 and travels with its transaction.

Decomposition:
- Package csa_pkg:
  - function clog2-based width helpers.
  - typedef s1_payload_t (sum, carry, parity, acc flag), parametrised by width via a localparam in the module.
  - function fa3 (bitwise 3:2 compress returning sum and carry).
- Sub-module csa_tree: a purely combinational N-to-2 Wallace reduction built with a generate loop of fa3 layers. It is reused by later multiplier blocks.
- Top csa_sum_pipe holds the handshake, the S1/S2 registers and the accumulator.

Test Plan:
- Reset then single transfer: N=4, W=8, operands 0x01,0x02,0x03,0x04, in_acc=0 -> out_sum=10 exactly 2 cycles later; out_parity=1 (total set bits = 5); out_valid pulses 1 cycle with out_ready=1.
- Max values: all operands 0xFF -> out_sum=1020 (0x3FC); no ovf; parity=0 (32 bits set).
- Backpressure: stream 5 bundles back-to-back with out_ready held 0 for cycles 3-6 -> in_ready drops after 2 accepted; all 5 results emerge in order with no loss or duplicate; out_sum is stable while stalled.
- Accumulate: three bundles summing 100, 200, 50 with in_acc=1 -> out_sum 100, 300, 350. acc_clr plus a bundle summing 7 with in_acc=1 on the same edge -> 7.
- Overflow: OW=14, preload acc by repeated 1020 sums (17 transactions) -> 17340 wraps to 17340-16384=956; out_ovf=1 and stays 1 until acc_clr.
- Reset mid-stream: assert rst_n=0 with 2 transactions in flight -> next cycle out_valid=0, acc=0; the first post-reset bundle produces the correct result with no stale output.
